// File: rtl/lfsr_pkg.sv
// Shared constants and FSM state type for the x^4+x^3+1 PRBS checker.
package lfsr_pkg;

   localparam int LFSR_W = 4;
   localparam int TAP_A  = 3;
   localparam int TAP_B  = 2;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != '1)) begin
         q_d = q_q + ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker (x^4+x^3+1) with lock/loss detection and error count.
// Define LFSR_CHECKER_FLYWHEEL_EN to let the locked history run on its own predictions.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int LOCK_LEN = 15,
   parameter int LOSS_LEN = 4,
   parameter int COUNT_W  = 16
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               din,
   input  logic               din_valid,
   input  logic               clear_count,
   output logic               locked,
   output logic               err,
   output logic [COUNT_W-1:0] err_count,
   output logic [1:0]         state
);

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_LEN - 1);
   localparam logic [3:0] LOSS_LAST = 4'(LOSS_LEN - 1);

   state_t            state_q, state_d;
   logic [LFSR_W-1:0] h_q, h_d;
   logic [1:0]        fill_q, fill_d;
   logic [7:0]        match_q, match_d;
   logic [3:0]        miss_q, miss_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;
   logic              pred;
   logic              mismatch;
   logic              locked_shift;

   assign pred     = h_q[TAP_A] ^ h_q[TAP_B];
   assign mismatch = din ^ pred;

`ifdef LFSR_CHECKER_FLYWHEEL_EN
   assign locked_shift = pred;
`else
   assign locked_shift = din;
`endif

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      fill_d  = fill_q;
      match_d = match_q;
      miss_d  = miss_q;
      err_d   = 1'b0;
      if (din_valid) begin
         case (state_q)
            FILL: begin
               h_d = {h_q[LFSR_W-2:0], din};
               if (fill_q == 2'd3) begin
                  state_d = VERIFY;
                  fill_d  = 2'd0;
               end else begin
                  fill_d = fill_q + 2'd1;
               end
            end
            VERIFY: begin
               h_d = {h_q[LFSR_W-2:0], din};
               // An all-zero history predicts zero forever, so it never counts as a match.
               if (!mismatch && (h_q != '0)) begin
                  if (match_q == LOCK_LAST) begin
                     state_d = LOCKED;
                     match_d = 8'd0;
                  end else begin
                     match_d = match_q + 8'd1;
                  end
               end else begin
                  match_d = 8'd0;
               end
            end
            LOCKED: begin
               h_d = {h_q[LFSR_W-2:0], locked_shift};
               if (mismatch) begin
                  err_d = 1'b1;
                  if (miss_q == LOSS_LAST) begin
                     state_d = FILL;
                     h_d     = '0;
                     miss_d  = 4'd0;
                     fill_d  = 2'd0;
                  end else begin
                     miss_d = miss_q + 4'd1;
                  end
               end else begin
                  miss_d = 4'd0;
               end
            end
            default: begin
               state_d = FILL;
            end
         endcase
      end
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         state_q  <= FILL;
         h_q      <= '0;
         fill_q   <= 2'd0;
         match_q  <= 8'd0;
         miss_q   <= 4'd0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         fill_q   <= fill_d;
         match_q  <= match_d;
         miss_q   <= miss_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   sat_counter #(
      .W (COUNT_W)
   ) u_err_cnt (
      .clock (clock),
      .rst   (rst),
      .inc   (err_d),
      .clr   (clear_count),
      .q     (err_count)
   );

   assign locked = locked_q;
   assign err    = err_q;
   assign state  = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker: cycle scoreboard against a queue-based model plus scenario checks.
`timescale 1ns/1ps
module tb_lfsr_checker;

   localparam int CW       = 3;
   localparam int MAXC     = (1 << CW) - 1;
   localparam int LOCK_LEN = 15;
   localparam int LOSS_LEN = 4;
`ifdef LFSR_CHECKER_FLYWHEEL_EN
   localparam bit FLY        = 1'b1;
   localparam int EXP_SINGLE = 1;
`else
   localparam bit FLY        = 1'b0;
   localparam int EXP_SINGLE = 3;
`endif

   logic          clock = 1'b0;
   logic          rst = 1'b0;
   logic          din = 1'b0;
   logic          din_valid = 1'b0;
   logic          clear_count = 1'b0;
   logic          locked;
   logic          err;
   logic [CW-1:0] err_count;
   logic [1:0]    state;

   int n_cmp = 0;
   int n_bad = 0;

   lfsr_checker #(
      .LOCK_LEN (LOCK_LEN),
      .LOSS_LEN (LOSS_LEN),
      .COUNT_W  (CW)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .clear_count (clear_count),
      .locked      (locked),
      .err         (err),
      .err_count   (err_count),
      .state       (state)
   );

   always #5 clock = ~clock;

   // Reference model: last four received bits in a queue, oldest first.
   bit mq[$] = '{1'b0, 1'b0, 1'b0, 1'b0};
   int m_state = 0;
   int m_fill  = 0;
   int m_match = 0;
   int m_miss  = 0;
   int m_cnt   = 0;
   bit m_err   = 1'b0;

   always @(posedge clock) begin : model
      bit p;
      bit nb;
      int ones;
      if (!rst) begin
         m_state = 0; m_fill = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_err = 1'b0;
         mq = '{1'b0, 1'b0, 1'b0, 1'b0};
      end else begin
         m_err = 1'b0;
         if (din_valid) begin
            p = mq[0] ^ mq[1];
            ones = 0;
            foreach (mq[i]) ones += int'(mq[i]);
            nb = din;
            if (m_state == 0) begin
               m_fill++;
               if (m_fill == 4) begin m_state = 1; m_fill = 0; end
            end else if (m_state == 1) begin
               if (din == p && ones != 0) m_match++;
               else m_match = 0;
               if (m_match == LOCK_LEN) begin m_state = 2; m_match = 0; end
            end else begin
               if (FLY) nb = p;
               if (din != p) begin m_err = 1'b1; m_miss++; end
               else m_miss = 0;
            end
            mq.push_back(nb);
            void'(mq.pop_front());
            if (m_state == 2 && m_miss == LOSS_LEN) begin
               m_state = 0; m_miss = 0; m_fill = 0;
               mq = '{1'b0, 1'b0, 1'b0, 1'b0};
            end
         end
         if (clear_count) m_cnt = 0;
         else if (m_err && m_cnt < MAXC) m_cnt++;
      end
   end

   always @(negedge clock) begin : scoreboard
      n_cmp++;
      if (locked !== (m_state == 2) || err !== m_err || err_count !== CW'(m_cnt) || state !== 2'(m_state)) begin
         n_bad++;
         $display("FAIL scoreboard t=%0t: got locked=%b err=%b cnt=%0d state=%0d, want locked=%b err=%b cnt=%0d state=%0d",
                  $time, locked, err, err_count, state, (m_state == 2), m_err, m_cnt, m_state);
      end
   end

   // Generator: emits seed 1111 first, then b(n) = b(n-3) ^ b(n-4).
   bit gq[$];
   int g_idx;

   task automatic gen_reset();
      gq = '{1'b1, 1'b1, 1'b1, 1'b1};
      g_idx = 0;
   endtask

   task automatic gen(output bit b);
      if (g_idx < 4) begin
         b = gq[g_idx];
         g_idx++;
      end else begin
         b = gq[1] ^ gq[0];
         gq.push_back(b);
         void'(gq.pop_front());
      end
   endtask

   task automatic tick(input bit rn, input bit v, input bit d, input bit clr);
      rst = rn; din_valid = v; din = d; clear_count = clr;
      @(posedge clock);
      #1;
   endtask

   task automatic clean(input int n, inout int pulses);
      bit b;
      for (int i = 0; i < n; i++) begin
         gen(b);
         tick(1'b1, 1'b1, b, 1'b0);
         if (err) pulses++;
      end
   endtask

   task automatic test_reset();
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if ({locked, err, err_count, state} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got locked=%b err=%b cnt=%0d state=%0d, want all 0", locked, err, err_count, state);
      end
      $display("test_reset: locked=%b cnt=%0d state=%0d", locked, err_count, state);
   endtask

   task automatic test_clean_lock();
      bit b;
      int pulses = 0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      gen_reset();
      for (int i = 1; i <= 200; i++) begin
         gen(b);
         tick(1'b1, 1'b1, b, 1'b0);
         if (err) pulses++;
         if (i == 18 || i == 19) begin
            n_cmp++;
            if (locked !== (i == 19)) begin
               n_bad++;
               $display("FAIL clean_lock_edge sample %0d: got locked=%b want %b", i, locked, (i == 19));
            end
         end
      end
      n_cmp++;
      if (pulses != 0 || err_count !== 3'd0 || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL clean_lock_200: got pulses=%0d cnt=%0d locked=%b, want 0 0 1", pulses, err_count, locked);
      end
      $display("test_clean_lock: pulses=%0d cnt=%0d locked=%b", pulses, err_count, locked);
   endtask

   task automatic test_lockup();
      int bad = 0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 100; i++) begin
         tick(1'b1, 1'b1, 1'b0, 1'b0);
         if (locked !== 1'b0 || err !== 1'b0 || state !== ((i < 4) ? 2'd0 : 2'd1)) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL lockup_reject: got %0d bad cycles (last state=%0d locked=%b), want 0", bad, state, locked);
      end
      $display("test_lockup: bad_cycles=%0d state=%0d", bad, state);
   endtask

   task automatic test_single_error();
      bit b;
      int pulses = 0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      gen_reset();
      clean(25, pulses);
      pulses = 0;
      gen(b);
      tick(1'b1, 1'b1, ~b, 1'b0);
      if (err) pulses++;
      clean(20, pulses);
      n_cmp++;
      if (pulses != EXP_SINGLE || err_count !== CW'(EXP_SINGLE) || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL single_error: got pulses=%0d cnt=%0d locked=%b, want %0d %0d 1",
                  pulses, err_count, locked, EXP_SINGLE, EXP_SINGLE);
      end
      $display("test_single_error: pulses=%0d cnt=%0d", pulses, err_count);
   endtask

   task automatic test_loss_relock();
      bit b;
      int pulses = 0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      gen_reset();
      clean(25, pulses);
      pulses = 0;
      for (int k = 1; k <= 4; k++) begin
         gen(b);
         tick(1'b1, 1'b1, ~b, 1'b0);
         if (err) pulses++;
`ifdef LFSR_CHECKER_FLYWHEEL_EN
         n_cmp++;
         if (locked !== (k < 4) || err !== 1'b1) begin
            n_bad++;
            $display("FAIL loss_bit %0d: got locked=%b err=%b, want %b 1", k, locked, err, (k < 4));
         end
`endif
      end
`ifdef LFSR_CHECKER_FLYWHEEL_EN
      for (int i = 1; i <= 19; i++) begin
         gen(b);
         tick(1'b1, 1'b1, b, 1'b0);
         if (i >= 18) begin
            n_cmp++;
            if (locked !== (i == 19) || err_count !== 3'd4) begin
               n_bad++;
               $display("FAIL relock sample %0d: got locked=%b cnt=%0d, want %b 4", i, locked, err_count, (i == 19));
            end
         end
      end
`else
      clean(40, pulses);
`endif
      $display("test_loss_relock: pulses=%0d cnt=%0d locked=%b", pulses, err_count, locked);
   endtask

   task automatic test_saturation();
      bit b;
      int pulses = 0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      gen_reset();
      clean(25, pulses);
      for (int k = 0; k < 10; k++) begin
         gen(b);
         tick(1'b1, 1'b1, ~b, 1'b0);
         clean(9, pulses);
      end
      n_cmp++;
      if (err_count !== 3'd7) begin
         n_bad++;
         $display("FAIL saturate: got cnt=%0d want 7", err_count);
      end
      gen(b);
      tick(1'b1, 1'b1, ~b, 1'b1);
      n_cmp++;
      if (err !== 1'b1 || err_count !== 3'd0) begin
         n_bad++;
         $display("FAIL clear_priority: got err=%b cnt=%0d, want 1 0", err, err_count);
      end
      $display("test_saturation: cnt=%0d err=%b", err_count, err);
   endtask

   task automatic test_gaps_and_reset();
      bit b;
      int vc = 0;
      int idle_err = 0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      gen_reset();
      while (vc < 60) begin
         if ($urandom_range(0, 2) == 0) begin
            tick(1'b1, 1'b0, 1'($urandom), 1'b0);
            if (err !== 1'b0) idle_err++;
         end else begin
            gen(b);
            tick(1'b1, 1'b1, b, 1'b0);
            vc++;
            if (vc == 18 || vc == 19) begin
               n_cmp++;
               if (locked !== (vc == 19)) begin
                  n_bad++;
                  $display("FAIL gap_lock_edge valid %0d: got locked=%b want %b", vc, locked, (vc == 19));
               end
            end
         end
      end
      n_cmp++;
      if (idle_err != 0) begin
         n_bad++;
         $display("FAIL gap_idle_err: got %0d err pulses on idle cycles, want 0", idle_err);
      end
      gen(b);
      tick(1'b1, 1'b1, ~b, 1'b0);
      n_cmp++;
      if (err_count !== 3'd1 || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL gap_error: got cnt=%0d locked=%b, want 1 1", err_count, locked);
      end
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (locked !== 1'b0 || err_count !== 3'd0 || state !== 2'd0) begin
         n_bad++;
         $display("FAIL midlock_reset: got locked=%b cnt=%0d state=%0d, want 0 0 0", locked, err_count, state);
      end
      $display("test_gaps_and_reset: valid=%0d state=%0d", vc, state);
   endtask

   task automatic test_random();
      bit b;
      int locks = 0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      gen_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) < 2) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            gen_reset();
         end else if ($urandom_range(0, 9) < 8) begin
            gen(b);
            if ($urandom_range(0, 99) < 3) b = ~b;
            tick(1'b1, 1'b1, b, ($urandom_range(0, 49) == 0));
         end else begin
            tick(1'b1, 1'b0, 1'($urandom), ($urandom_range(0, 49) == 0));
         end
         if (locked) locks++;
      end
      $display("test_random: locked_cycles=%0d", locks);
   endtask

   initial begin
      gen_reset();
      test_reset();
      test_clean_lock();
      test_lockup();
      test_single_error();
      test_loss_relock();
      test_saturation();
      test_gaps_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial PRBS checker for the 4-bit Fibonacci LFSR stream, polynomial x^4+x^3+1, period 15, where each new bit b(n) = b(n-3) XOR b(n-4). It sits at the receive end of a link driven by the LFSR generator and self-synchronises to the incoming bit stream. It declares lock and loss-of-lock, and flags and counts bit errors for link BER testing.

## Interface
- LOCK_LEN, 15, consecutive correct predictions needed to declare lock (1..255)
- LOSS_LEN, 4, consecutive mispredictions while locked that force a resync (1..15)
- COUNT_W, 16, width of the saturating error counter (>=2)

Ports:
- clock  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-low reset
- din  in  1  received serial bit
- din_valid  in  1  din is sampled only on cycles where this is high
- clear_count  in  1  synchronous clear of err_count
- locked  out  1  checker is in LOCKED state
- err  out  1  one-cycle pulse: the last sampled bit mismatched the prediction while locked
- err_count  out  COUNT_W  saturating count of errors
- state  out  2  current FSM state (debug)

## Operation
- History register h[3:0] holds the last four bits: h[0] is the newest, h[3] the oldest. Prediction p = h[2] XOR h[3].
- FSM states are FILL=0, VERIFY=1, LOCKED=2.
- FILL:
  - Each valid bit shifts into h as {h[2:0],din} and increments fill_cnt.
  - After the 4th valid bit, go to VERIFY with fill_cnt cleared.
- VERIFY:
  - Each valid bit shifts din into h.
  - If din==p and h!=0, increment match_cnt. Otherwise clear match_cnt.
  - The h!=0 condition rejects the all-zero lockup stream.
  - When match_cnt reaches LOCK_LEN, go to LOCKED and clear match_cnt.
  - err is never asserted in this state.
- LOCKED:
  - Each valid bit is compared with p.
  - On mismatch: assert err, increment err_count, increment miss_cnt.
  - On match: clear miss_cnt.
  - When miss_cnt reaches LOSS_LEN, go to FILL and clear h, miss_cnt and fill_cnt. err_count is kept.
  - The bit shifted into h is selected per Configuration.
- din_valid low: h, the counters and the state hold, and err=0.
- err_count:
  - Saturates at 2^COUNT_W-1.
  - clear_count has priority: if it coincides with an error, err_count becomes 0 and err still pulses.
- Reset (rst low at an edge):
  - state=FILL, h=0, all internal counters 0.
  - Outputs: locked=0, err=0, err_count=0, state=0.
  - Reset applies mid-lock with no special handling.

## Timing
- All outputs are registered.
- err is high for exactly the cycle following the edge that sampled the mismatching bit.
- err_count updates on that same edge.
- locked rises on the edge that samples the LOCK_LEN-th qualifying match. From reset with a clean stream this is the (4+LOCK_LEN)-th valid sample.
- locked falls on the edge that samples the LOSS_LEN-th consecutive mismatch. err is also high for that bit.
- The input has no backpressure. One bit is accepted per valid cycle, at full rate.

## Configuration
- LFSR_CHECKER_FLYWHEEL_EN defined:
  - In LOCKED, h shifts in p (the predicted bit), not din.
  - A single channel bit error therefore yields exactly one err pulse.
- Not defined:
  - In LOCKED, h shifts in din.
  - A single channel bit error yields up to 3 err pulses: once directly, then via taps h[2] and h[3].
- FILL and VERIFY always shift din.

## Structure
- Package lfsr_pkg contains:
  - LFSR_W=4
  - tap indices TAP_A=3, TAP_B=2
  - state enum {FILL, VERIFY, LOCKED}, 2 bits
- One sub-module, sat_counter (parameter W; inputs inc and clr, clr has priority; output q), implements err_count.
- FSM, history register and compare logic stay in lfsr_checker.

## Test plan
- Clean lock: after reset, drive the generator stream seeded 4'b1111 with din_valid=1. Expect locked=1 after the 19th sample edge, err never asserted, err_count=0 after 200 bits.
- Lockup rejection: drive 100 zero bits. Expect state alternating only FILL->VERIFY, locked=0, err=0 throughout.
- Single error, macro defined: after lock, invert one bit. Expect exactly one err pulse, err_count=1, locked stays 1. Without the macro, the same stimulus gives 3 pulses and err_count=3.
- Loss and relock, macro defined: after lock, invert 4 consecutive bits. Expect 4 err pulses, err_count=4, and locked falling with the 4th. Resume the clean stream: locked=1 again 19 valid bits later, err_count still 4.
- Saturation and clear, COUNT_W=3: inject 10 isolated errors. Expect err_count=7. Assert clear_count together with an 11th error: expect err_count=0 and err pulse=1.
- Gaps and reset:
  - Insert random din_valid=0 gaps. Expect behaviour identical to the gapless run.
  - Pull rst low while locked. At the next edge expect locked=0, err_count=0, state=FILL.
